// File: rtl/pn_pkg.sv
// pn_pkg: shared definitions for the PRBS7 scrambler family (scrambler,
// descrambler, PN checker).
//   pn_state_e       : scrambler FSM encoding, IDLE=0 HEADER=1 PAYLOAD=2
//   PRBS7_W          : LFSR width
//   PRBS7_TAP_HI/LO  : feedback taps for x^7 + x^6 + 1
//   PN_SEED_DEFAULT  : reload value at every frame start
//   prbs7_next()     : one Fibonacci step of the LFSR
package pn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } pn_state_e;

  localparam int PRBS7_W      = 7;
  localparam int PRBS7_TAP_HI = 6;
  localparam int PRBS7_TAP_LO = 5;

  localparam logic [PRBS7_W-1:0] PN_SEED_DEFAULT = 7'h7F;

  // The oldest bit (TAP_HI) is the PN output; feedback enters at bit 0.
  function automatic logic [PRBS7_W-1:0] prbs7_next(input logic [PRBS7_W-1:0] s);
    return {s[PRBS7_W-2:0], s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO]};
  endfunction

endpackage

// File: rtl/prbs7_lfsr.sv
// prbs7_lfsr: PRBS7 generator (x^7 + x^6 + 1, Fibonacci form).
//   clk_out : bit clock, rising edge
//   rst     : synchronous active-high reset, loads SEED
//   load    : reload SEED this edge (wins over advance)
//   advance : step the LFSR one bit this edge
//   pn      : current PN bit (lfsr[6]), valid before the step
module prbs7_lfsr
  import pn_pkg::*;
#(
  parameter logic [PRBS7_W-1:0] SEED = PN_SEED_DEFAULT
) (
  input  logic clk_out,
  input  logic rst,
  input  logic load,
  input  logic advance,
  output logic pn
);

  logic [PRBS7_W-1:0] lfsr_q;

  always_ff @(posedge clk_out) begin
    if (rst || load) begin
      lfsr_q <= SEED;
    end else if (advance) begin
      lfsr_q <= prbs7_next(lfsr_q);
    end
  end

  assign pn = lfsr_q[PRBS7_TAP_HI];

endmodule

// File: rtl/pn_scrambler.sv
// pn_scrambler: bit-serial PRBS7 frame scrambler. Header bits pass through,
// payload bits are XORed with a PN sequence reseeded at each frame start, so
// an identical instance downstream descrambles the stream.
//   clk_out         : bit clock, rising edge
//   rst             : synchronous active-high reset
//   data_in         : serial input bit
//   data_valid      : data_in accepted this edge
//   frame_start     : first bit of a frame (qualified by data_valid)
//   data_out        : registered scrambled/header bit (holds when not valid)
//   data_out_valid  : data_out updated this cycle
//   pn_out          : PN bit applied to data_out, 0 for header bits
//   frame_done      : pulse with the last output bit of a frame
//   frame_error     : pulse when frame_start arrives mid-frame
//   scrambler_state : current FSM state
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | between frames; bits without frame_start are discarded
// ST_HEADER  | passing header bits 1..HEADER_LEN-1 unscrambled
// ST_PAYLOAD | scrambling payload bits, LFSR steps per accepted bit
//
// FRAME_LEN >= 2, 1 <= HEADER_LEN < FRAME_LEN, PN_SEED != 0.
module pn_scrambler
  import pn_pkg::*;
#(
  parameter int                 FRAME_LEN  = 56,
  parameter int                 HEADER_LEN = 8,
  parameter logic [PRBS7_W-1:0] PN_SEED    = PN_SEED_DEFAULT
) (
  input  logic       clk_out,
  input  logic       rst,
  input  logic       data_in,
  input  logic       data_valid,
  input  logic       frame_start,
  output logic       data_out,
  output logic       data_out_valid,
  output logic       pn_out,
  output logic       frame_done,
  output logic       frame_error,
  output logic [1:0] scrambler_state
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HEADER_LEN - 1);

  pn_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lfsr_load, lfsr_adv, pn_cur;
  logic             emit, out_bit, out_pn, done_d, err_d;

  prbs7_lfsr #(.SEED(PN_SEED)) u_lfsr (
    .clk_out (clk_out),
    .rst     (rst),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .pn      (pn_cur)
  );

  // State register plus output registers; outputs hold while nothing is emitted.
  always_ff @(posedge clk_out) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      data_out       <= 1'b0;
      data_out_valid <= 1'b0;
      pn_out         <= 1'b0;
      frame_done     <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      data_out_valid <= emit;
      frame_done     <= done_d;
      frame_error    <= err_d;
      if (emit) begin
        data_out <= out_bit;
        pn_out   <= out_pn;
      end
    end
  end

  // Next state. A qualified frame_start restarts a frame from any state,
  // which also covers the mid-frame abort.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    if (data_valid) begin
      if (frame_start) begin
        cnt_d     = CNT_W'(1);
        lfsr_load = 1'b1;
        state_d   = (HEADER_LEN == 1) ? ST_PAYLOAD : ST_HEADER;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_HEADER: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == HDR_LAST) state_d = ST_PAYLOAD;
          end
          ST_PAYLOAD: begin
            lfsr_adv = 1'b1;
            if (cnt_q == LAST_IDX) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  // Output values to be registered on this edge.
  always_comb begin
    emit    = 1'b0;
    out_bit = data_in;
    out_pn  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (data_valid) begin
      case (state_q)
        ST_IDLE: emit = frame_start;
        ST_HEADER: begin
          emit  = 1'b1;
          err_d = frame_start;
        end
        ST_PAYLOAD: begin
          emit  = 1'b1;
          err_d = frame_start;
          if (!frame_start) begin
            out_pn  = pn_cur;
            out_bit = data_in ^ pn_cur;
            done_d  = (cnt_q == LAST_IDX);
          end
        end
        default: ;
      endcase
    end
  end

  assign scrambler_state = state_q;

endmodule

// File: tb/tb_pn_scrambler.sv
// tb_pn_scrambler: randomized and directed bench for pn_scrambler with a
// stream-level reference model and a chained descrambler for round trips.
module tb_pn_scrambler;

  localparam int         FL   = 56;
  localparam int         HL   = 8;
  localparam logic [6:0] SEED = 7'h7F;

  logic clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  logic       rst = 1'b1;
  logic       data_in = 1'b0, data_valid = 1'b0, frame_start = 1'b0;
  logic       data_out, data_out_valid, pn_out, frame_done, frame_error;
  logic [1:0] scrambler_state;

  logic       fs_d;
  logic       d2_out, d2_valid, d2_pn, d2_done, d2_err;
  logic [1:0] d2_state;

  pn_scrambler #(.FRAME_LEN(FL), .HEADER_LEN(HL), .PN_SEED(SEED)) dut (
    .clk_out (clk_out), .rst (rst), .data_in (data_in), .data_valid (data_valid),
    .frame_start (frame_start), .data_out (data_out), .data_out_valid (data_out_valid),
    .pn_out (pn_out), .frame_done (frame_done), .frame_error (frame_error),
    .scrambler_state (scrambler_state)
  );

  // Downstream instance acts as the descrambler; frame_start is delayed to
  // line up with the first scrambler's registered output.
  always @(posedge clk_out) fs_d <= rst ? 1'b0 : (frame_start & data_valid);

  pn_scrambler #(.FRAME_LEN(FL), .HEADER_LEN(HL), .PN_SEED(SEED)) u_desc (
    .clk_out (clk_out), .rst (rst), .data_in (data_out), .data_valid (data_out_valid),
    .frame_start (fs_d), .data_out (d2_out), .data_out_valid (d2_valid),
    .pn_out (d2_pn), .frame_done (d2_done), .frame_error (d2_err),
    .scrambler_state (d2_state)
  );

  int   n_vec = 0, n_err = 0;
  int   pos = -1;
  logic held_do = 1'b0, held_pn = 1'b0;
  bit   pnseq [0:FL-HL-1];
  bit   rtq [$];
  bit   obs_do [$], obs_pn [$], obs_done [$], obs_err [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // PN sequence from the recurrence s[n] = s[n-7] ^ s[n-6], seed MSB first.
  task automatic build_pn();
    logic [6:0] s;
    s = SEED;
    for (int i = 0; i < FL - HL; i++)
      pnseq[i] = (i < 7) ? s[6-i] : (pnseq[i-7] ^ pnseq[i-6]);
  endtask

  task automatic obs_clear();
    obs_do.delete(); obs_pn.delete(); obs_done.delete(); obs_err.delete();
  endtask

  // One clock: model predicts, DUT is driven, outputs checked after the edge.
  task automatic drive(input logic din, input logic dv, input logic fs);
    logic       ev, ed, ee;
    logic [1:0] es;
    bit         pb;
    ev = 1'b0; ed = 1'b0; ee = 1'b0;
    if (dv && fs) begin
      ee = (pos >= 0); ev = 1'b1;
      held_do = din; held_pn = 1'b0; pos = 1;
      rtq.push_back(din);
    end else if (dv && pos >= 0) begin
      pb = (pos >= HL) ? pnseq[pos-HL] : 1'b0;
      ev = 1'b1; held_do = din ^ pb; held_pn = pb;
      ed = (pos == FL - 1);
      pos = ed ? -1 : pos + 1;
      rtq.push_back(din);
    end
    es = (pos < 0) ? 2'd0 : (pos < HL) ? 2'd1 : 2'd2;
    @(negedge clk_out);
    data_in = din; data_valid = dv; frame_start = fs;
    @(posedge clk_out); #1;
    chk("valid",    64'(data_out_valid),  64'(ev));
    chk("data_out", 64'(data_out),        64'(held_do));
    chk("pn_out",   64'(pn_out),          64'(held_pn));
    chk("done",     64'(frame_done),      64'(ed));
    chk("error",    64'(frame_error),     64'(ee));
    chk("state",    64'(scrambler_state), 64'(es));
    if (data_out_valid === 1'b1) begin
      obs_do.push_back(data_out); obs_pn.push_back(pn_out);
      obs_done.push_back(frame_done); obs_err.push_back(frame_error);
    end
  endtask

  task automatic reset_dut(input int n);
    @(negedge clk_out);
    rst = 1'b1; data_valid = 1'b1; frame_start = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk_out);
      data_in = 1'($urandom);
      @(posedge clk_out); #1;
      chk("rst_valid", 64'(data_out_valid), 64'd0);
      chk("rst_dout",  64'(data_out),       64'd0);
      chk("rst_pn",    64'(pn_out),         64'd0);
      chk("rst_done",  64'(frame_done),     64'd0);
      chk("rst_err",   64'(frame_error),    64'd0);
      chk("rst_state", 64'(scrambler_state), 64'd0);
    end
    rst = 1'b0; data_valid = 1'b0; frame_start = 1'b0;
    pos = -1; held_do = 1'b0; held_pn = 1'b0;
    rtq.delete();
  endtask

  // stall_after: frame index after which stall_len dead cycles are inserted
  // (-1 for none); gaps: random dead cycles with random frame_start.
  task automatic send_frame(input logic [7:0] hdr, input logic [47:0] pay,
                            input int stall_after, input int stall_len, input bit gaps);
    logic b;
    for (int i = 0; i < FL; i++) begin
      b = (i < HL) ? hdr[7-i] : pay[47-(i-HL)];
      drive(b, 1'b1, i == 0);
      if (i == stall_after)
        for (int k = 0; k < stall_len; k++) drive(1'($urandom), 1'b0, 1'($urandom));
      if (gaps && $urandom_range(0, 3) == 0) drive(1'($urandom), 1'b0, 1'($urandom));
    end
  endtask

  function automatic logic [47:0] rand_pay();
    logic [47:0] p;
    p[47:32] = 16'($urandom_range(0, 65535));
    p[31:0]  = $urandom();
    return p;
  endfunction

  always @(negedge clk_out) begin
    if (!rst && d2_valid === 1'b1) begin
      if (rtq.size() == 0) chk("rt_extra", 64'd1, 64'd0);
      else chk("rt_data", 64'(d2_out), 64'(rtq.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got16;
    logic [55:0] got56, ref56;
    logic [47:0] pay;
    logic [7:0]  hdr;
    int          cnt, idx, idx2;

    build_pn();
    hdr = 8'hA5;
    reset_dut(3);

    // All-zero payload frame
    obs_clear();
    send_frame(hdr, 48'h0, -1, 0, 1'b0);
    chk("zf_len", 64'(obs_do.size()), 64'd56);
    got16 = '0;
    for (int i = 0; i < 16; i++) got16 = {got16[14:0], logic'(obs_do[i])};
    chk("zf_dout16", 64'(got16), 64'hA5FE);
    got16 = '0;
    for (int i = 0; i < 16; i++) got16 = {got16[14:0], logic'(obs_pn[i])};
    chk("zf_pn16", 64'(got16), 64'h00FE);
    cnt = 0; idx = -1;
    foreach (obs_done[i]) if (obs_done[i]) begin cnt++; idx = i; end
    chk("zf_done_cnt", 64'(cnt), 64'd1);
    chk("zf_done_idx", 64'(idx), 64'd55);

    // Stall of 5 cycles after payload bit 10
    obs_clear();
    send_frame(hdr, 48'h0, HL + 9, 5, 1'b0);
    got56 = '0; ref56 = '0;
    for (int i = 0; i < FL; i++) begin
      got56 = {got56[54:0], (i < obs_do.size()) ? logic'(obs_do[i]) : 1'bx};
      ref56 = {ref56[54:0], (i < HL) ? hdr[7-i] : logic'(pnseq[i-HL])};
    end
    chk("stall_len", 64'(obs_do.size()), 64'd56);
    chk("stall_stream", 64'(got56), 64'(ref56));

    // Mid-frame restart on frame bit 30
    obs_clear();
    pay = rand_pay();
    for (int i = 0; i < 30; i++)
      drive((i < HL) ? hdr[7-i] : pay[47-(i-HL)], 1'b1, i == 0);
    send_frame(hdr, 48'h0, -1, 0, 1'b0);
    cnt = 0; idx = -1;
    foreach (obs_err[i]) if (obs_err[i]) begin cnt++; idx = i; end
    chk("rs_err_cnt", 64'(cnt), 64'd1);
    chk("rs_err_idx", 64'(idx), 64'd30);
    got16 = '0;
    for (int i = 30; i < 46; i++) got16 = {got16[14:0], logic'(obs_pn[i])};
    chk("rs_pn16", 64'(got16), 64'h00FE);
    cnt = 0; idx = -1;
    foreach (obs_done[i]) if (obs_done[i]) begin cnt++; idx = i; end
    chk("rs_done_cnt", 64'(cnt), 64'd1);
    chk("rs_done_idx", 64'(idx), 64'd85);

    // Reset in the middle of a frame
    for (int i = 0; i < 20; i++) drive(1'($urandom), 1'b1, i == 0);
    reset_dut(2);

    // Discard in IDLE, then two back-to-back frames
    obs_clear();
    for (int i = 0; i < 3; i++) drive(1'($urandom), 1'b1, 1'b0);
    chk("disc_cnt", 64'(obs_do.size()), 64'd0);
    send_frame(hdr, rand_pay(), -1, 0, 1'b0);
    send_frame(hdr, rand_pay(), -1, 0, 1'b0);
    chk("b2b_len", 64'(obs_do.size()), 64'd112);
    cnt = 0; idx = -1; idx2 = -1;
    foreach (obs_done[i]) if (obs_done[i]) begin
      cnt++;
      if (idx < 0) idx = i; else idx2 = i;
    end
    chk("b2b_done_cnt", 64'(cnt), 64'd2);
    chk("b2b_done_gap", 64'(idx2 - idx), 64'd56);

    // Round trip: 20 random frames with random gaps
    for (int f = 0; f < 20; f++) send_frame(hdr, rand_pay(), -1, 0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'($urandom), 1'b0, 1'b0);
    chk("rt_drain", 64'(rtq.size()), 64'd0);

    // Random stress including spurious frame_starts
    for (int i = 0; i < 600; i++)
      drive(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    for (int i = 0; i < FL + 4; i++) drive(1'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'($urandom), 1'b0, 1'b0);
    chk("stress_drain", 64'(rtq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
